// File: rtl/mult_div_unit_pkg.sv
// Shared opcodes, default latencies and the signed-divide helper for the HI/LO
// multiply/divide unit.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int MDU_MULT_CYC = 5;
  localparam int MDU_DIV_CYC  = 10;

  function automatic logic is_launch_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Divides magnitudes, then fixes signs, so 0x80000000 / -1 wraps to 0x80000000
  // instead of overflowing a signed divider. Returns {remainder, quotient}.
  function automatic logic [63:0] signed_divide(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] quo;
    logic [31:0] rem;
    mag_a = a[31] ? (~a + 32'd1) : a;
    mag_b = b[31] ? (~b + 32'd1) : b;
    mag_q = mag_a / mag_b;
    mag_r = mag_a % mag_b;
    quo   = (a[31] ^ b[31]) ? (~mag_q + 32'd1) : mag_q;
    rem   = a[31] ? (~mag_r + 32'd1) : mag_r;
    return {rem, quo};
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// EX-stage HI/LO multiply/divide unit with fixed multi-cycle latency, running
// beside the ALU on the same forwarded rs/rt operands.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYC,
  parameter int DIV_CYCLES  = MDU_DIV_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUresult
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Handshake: start is a one-cycle launch request with no ready. It is accepted
  // only when busy is low and MDUOp is mult/multu/div/divu; otherwise it is
  // dropped. The hazard unit stalls MDU instructions while (busy | start).

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  mdu_op_e          op_q, op_d;

  logic [63:0]      result;
  logic             div_zero;

  // 64-bit product/quotient mux over the latched operands
  always_comb begin
    result   = {hi_q, lo_q};
    div_zero = (b_q == 32'd0);
    case (op_q)
      MDU_MULT:  result = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
      MDU_MULTU: result = {32'd0, a_q} * {32'd0, b_q};
      MDU_DIV:   if (!div_zero) result = signed_divide(a_q, b_q);
      MDU_DIVU:  if (!div_zero) result = {a_q % b_q, a_q / b_q};
      default:   result = {hi_q, lo_q};
    endcase
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        hi_d   = result[63:32];
        lo_d   = result[31:0];
      end
    end else if (start && is_launch_op(MDUOp)) begin
      a_d    = A;
      b_d    = B;
      op_d   = mdu_op_e'(MDUOp);
      busy_d = 1'b1;
      cnt_d  = ((MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU)) ? CNT_W'(MULT_CYCLES)
                                                              : CNT_W'(DIV_CYCLES);
    end else if (MDUOp == MDU_MTHI) begin
      hi_d = A;
    end else if (MDUOp == MDU_MTLO) begin
      lo_d = A;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= MDU_NONE;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
    end
  end

  always_comb begin
    MDUresult = 32'd0;
    if (MDUOp == MDU_MFHI) MDUresult = hi_q;
    else if (MDUOp == MDU_MFLO) MDUresult = lo_q;
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_mult_div_unit;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam int N_MULT = 5;
  localparam int N_DIV  = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  mdu_op;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_result;

  mult_div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .MDUOp     (mdu_op),
    .start     (start),
    .A         (a_in),
    .B         (b_in),
    .busy      (busy),
    .HI        (hi),
    .LO        (lo),
    .MDUresult (mdu_result)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- counters / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic prev_busy = 1'b0;
  logic last_rst_low = 1'b0;

  // ---------------- reference model ----------------
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          m_left = 0;
  logic [3:0]  m_op = 4'd0;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd0;

  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] cur_hi,
                                             input logic [31:0] cur_lo);
    longint sa;
    longint sb;
    longint prod;
    longint q;
    longint r;
    logic [63:0] qv;
    logic [63:0] rv;
    logic [63:0] ua;
    logic [63:0] ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MULT: begin
        prod = sa * sb;
        return prod;
      end
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 32'd0) return {cur_hi, cur_lo};
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {cur_hi, cur_lo};
        qv = ua / ub;
        rv = ua % ub;
        return {rv[31:0], qv[31:0]};
      end
      default: return {cur_hi, cur_lo};
    endcase
  endfunction

  task automatic model_step(input logic [3:0] op, input logic st, input logic [31:0] a,
                            input logic [31:0] b, input logic rst_n);
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_op = 0; m_a = 0; m_b = 0;
      exp_q.delete();
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        {m_hi, m_lo} = ref_result(m_op, m_a, m_b, m_hi, m_lo);
        exp_q.push_back({m_hi, m_lo});
      end
    end else if (st && op >= OP_MULT && op <= OP_DIVU) begin
      m_op = op; m_a = a; m_b = b;
      m_left = (op == OP_MULT || op == OP_MULTU) ? N_MULT : N_DIV;
    end else if (op == OP_MTHI) begin
      m_hi = a;
    end else if (op == OP_MTLO) begin
      m_lo = a;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] exp_res;
    exp_res = (mdu_op == OP_MFHI) ? m_hi : (mdu_op == OP_MFLO) ? m_lo : 32'd0;
    chk("busy", {63'd0, busy}, {63'd0, m_left > 0});
    chk("hi", {32'd0, hi}, {32'd0, m_hi});
    chk("lo", {32'd0, lo}, {32'd0, m_lo});
    chk("mdu_result", {32'd0, mdu_result}, {32'd0, exp_res});
    if (!last_rst_low && prev_busy && !busy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_hilo: completion with hi=0x%0h lo=0x%0h, expected no completion", hi, lo);
      end else begin
        chk("sb_hilo", {hi, lo}, exp_q.pop_front());
      end
    end
    prev_busy = busy;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [3:0] op, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic rst_n);
    mdu_op = op; start = st; a_in = a; b_in = b; reset = rst_n;
    @(posedge clk);
    model_step(op, st, a, b, rst_n);
    last_rst_low = !rst_n;
    #1;
    check_outputs();
  endtask

  task automatic idle();
    cycle(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  // Counts samples (including the current one) with busy high, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      idle();
    end
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n;
    logic [3:0] rop;
    logic       rst_n;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,         N_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,         N_MULT, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         N_DIV,  32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, N_DIV,  32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{OP_DIVU,  32'd7,         32'd2,         N_DIV,  32'h0000_0001, 32'h0000_0003};
    vecs[5] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, N_DIV,  32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, N_MULT, 32'h4000_0000, 32'h0000_0000};
    vecs[7] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, N_MULT, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[8] = '{OP_DIVU,  32'd7,         32'd0,         N_DIV,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[9] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         N_DIV,  32'hFFFF_FFFE, 32'h0000_0001};

    // reset
    cycle(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
    cycle(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);

    foreach (vecs[i]) begin
      cycle(vecs[i].op, 1'b1, vecs[i].a, vecs[i].b, 1'b1);
      wait_idle(n);
      chk($sformatf("vec%0d_cycles", i), 64'(n), 64'(vecs[i].cycles));
      chk($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].exp_hi});
      chk($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].exp_lo});
    end

    // multu then mfhi / mflo
    cycle(OP_MULTU, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_idle(n);
    cycle(OP_MFHI, 1'b0, 32'd0, 32'd0, 1'b1);
    chk("mfhi_read", {32'd0, mdu_result}, 64'd1);
    cycle(OP_MFLO, 1'b0, 32'd0, 32'd0, 1'b1);
    chk("mflo_read", {32'd0, mdu_result}, 64'hFFFF_FFFE);

    // mthi while idle; mtlo with start asserted still writes
    cycle(OP_MTHI, 1'b0, 32'h1234_5678, 32'd0, 1'b1);
    chk("mthi_hi", {32'd0, hi}, 64'h1234_5678);
    cycle(OP_MTLO, 1'b1, 32'hCAFE_F00D, 32'd0, 1'b1);
    chk("mtlo_start_lo", {32'd0, lo}, 64'hCAFE_F00D);
    chk("mtlo_start_busy", {63'd0, busy}, 64'd0);

    // mtlo mid-mult is ignored
    cycle(OP_MULT, 1'b1, 32'd2, 32'd3, 1'b1);
    idle();
    cycle(OP_MTLO, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1);
    wait_idle(n);
    chk("mtlo_busy_lo", {32'd0, lo}, 64'd6);
    chk("mtlo_busy_hi", {32'd0, hi}, 64'd0);

    // second start two cycles into a div is ignored
    cycle(OP_DIV, 1'b1, 32'd100, 32'd7, 1'b1);
    idle();
    cycle(OP_MULT, 1'b1, 32'd2, 32'd3, 1'b1);
    wait_idle(n);
    chk("restart_cycles", 64'(n + 2), 64'(N_DIV));
    chk("restart_lo", {32'd0, lo}, 64'd14);
    chk("restart_hi", {32'd0, hi}, 64'd2);

    // reset in cycle 3 of a mult abandons it
    cycle(OP_MULT, 1'b1, 32'd7, 32'd9, 1'b1);
    idle();
    cycle(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_hi", {32'd0, hi}, 64'd0);
    chk("midrst_lo", {32'd0, lo}, 64'd0);
    repeat (8) idle();
    chk("midrst_later", {hi, lo}, 64'd0);

    // randomized traffic against the model
    repeat (600) begin
      rop   = 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 149) != 0);
      cycle(rop, $urandom_range(0, 2) == 0, rand_word(), rand_word(), rst_n);
    end
    wait_idle(n);
    chk("drain_busy", {63'd0, busy}, 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
